// File: rtl/store_unit.sv
// Store unit: lane-aligns RV32I store data, builds the byte mask and drives a
// held valid/ready write request to data memory with stall, misalign and timeout reporting.
module store_unit #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        st_valid_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] rs2_in,
  input  logic        bus_ready_in,
  output logic        bus_req_out,
  output logic [31:0] bus_addr_out,
  output logic [31:0] bus_wdata_out,
  output logic [3:0]  bus_wmask_out,
  output logic        stall_out,
  output logic        done_out,
  output logic        misaligned_out,
  output logic [31:0] misaligned_addr_out,
  output logic        bus_err_out
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_REQ  = 1'b1;

  localparam bit              TO_EN    = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  function automatic logic [31:0] fmt_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      F3_SB:   fmt_wdata = {4{d[7:0]}};
      F3_SH:   fmt_wdata = {2{d[15:0]}};
      default: fmt_wdata = d;
    endcase
  endfunction

  function automatic logic [3:0] fmt_wmask(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      F3_SB:   fmt_wmask = 4'b0001 << a;
      F3_SH:   fmt_wmask = a[1] ? 4'b1100 : 4'b0011;
      default: fmt_wmask = 4'b1111;
    endcase
  endfunction

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_req;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [3:0]       r_wmask;
  logic             r_done;
  logic             r_mis;
  logic [31:0]      r_mis_addr;
  logic             r_err;

  logic w_legal;
  logic w_misal;
  logic w_stall;
  logic w_hs;
  logic w_timeout;
  logic w_accept;
  logic w_mis_evt;

  assign w_legal   = (funct3_in == F3_SB) || (funct3_in == F3_SH) || (funct3_in == F3_SW);
  assign w_misal   = ((funct3_in == F3_SH) && addr_in[0]) ||
                     ((funct3_in == F3_SW) && (addr_in[1:0] != 2'b00));
  assign w_stall   = (r_state == S_REQ) && !bus_ready_in;
  assign w_hs      = (r_state == S_REQ) && bus_ready_in;
  // The cycle whose increment would reach the limit is the abort cycle.
  assign w_timeout = TO_EN && w_stall && (r_cnt == LIMIT_M1);
  assign w_accept  = st_valid_in && w_legal && !w_misal && ((r_state == S_IDLE) || w_hs);
  // A held store only reports its misalignment once the pipeline releases it.
  assign w_mis_evt = st_valid_in && w_legal && w_misal && !w_stall;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_req      <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wmask    <= '0;
      r_done     <= 1'b0;
      r_mis      <= 1'b0;
      r_mis_addr <= '0;
      r_err      <= 1'b0;
    end else begin
      r_done <= w_hs;
      r_err  <= w_timeout;
      r_mis  <= w_mis_evt;
      if (w_mis_evt) r_mis_addr <= addr_in;

      if (w_accept) begin
        r_state <= S_REQ;
        r_req   <= 1'b1;
        r_addr  <= {addr_in[31:2], 2'b00};
        r_wdata <= fmt_wdata(funct3_in, rs2_in);
        r_wmask <= fmt_wmask(funct3_in, addr_in[1:0]);
        r_cnt   <= '0;
      end else if (w_hs || w_timeout) begin
        r_state <= S_IDLE;
        r_req   <= 1'b0;
        r_cnt   <= '0;
      end else if (w_stall) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign bus_req_out         = r_req;
  assign bus_addr_out        = r_addr;
  assign bus_wdata_out       = r_wdata;
  assign bus_wmask_out       = r_wmask;
  assign stall_out           = w_stall;
  assign done_out            = r_done;
  assign misaligned_out      = r_mis;
  assign misaligned_addr_out = r_mis_addr;
  assign bus_err_out         = r_err;

endmodule

// File: tb/tb_store_unit.sv
// Scoreboard bench for store_unit: expected writes are queued at issue and
// compared against the bus while a request is up; pulse counts are checked per scenario.
module tb_store_unit;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } wr_t;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        st_valid_in;
  logic [2:0]  funct3_in;
  logic [31:0] addr_in;
  logic [31:0] rs2_in;
  logic        bus_ready_in;
  logic        bus_req_out;
  logic [31:0] bus_addr_out;
  logic [31:0] bus_wdata_out;
  logic [3:0]  bus_wmask_out;
  logic        stall_out;
  logic        done_out;
  logic        misaligned_out;
  logic [31:0] misaligned_addr_out;
  logic        bus_err_out;

  store_unit #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .st_valid_in(st_valid_in),
    .funct3_in(funct3_in), .addr_in(addr_in), .rs2_in(rs2_in),
    .bus_ready_in(bus_ready_in), .bus_req_out(bus_req_out),
    .bus_addr_out(bus_addr_out), .bus_wdata_out(bus_wdata_out),
    .bus_wmask_out(bus_wmask_out), .stall_out(stall_out), .done_out(done_out),
    .misaligned_out(misaligned_out), .misaligned_addr_out(misaligned_addr_out),
    .bus_err_out(bus_err_out)
  );

  always #5 clk_in = ~clk_in;

  int  n_vec = 0;
  int  n_miss = 0;
  wr_t exp_q[$];

  int n_req = 0, n_stall = 0, n_done = 0, n_err = 0, n_mis = 0;
  int b_req, b_stall, b_done, b_err, b_mis;
  logic hs_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic snap();
    b_req = n_req; b_stall = n_stall; b_done = n_done; b_err = n_err; b_mis = n_mis;
  endtask

  task automatic chk_counts(input string tag, input int req, input int stall,
                            input int done, input int err, input int mis);
    chk({tag, "_req_cycles"}, 32'(n_req - b_req), 32'(req));
    chk({tag, "_stall_cycles"}, 32'(n_stall - b_stall), 32'(stall));
    chk({tag, "_done_pulses"}, 32'(n_done - b_done), 32'(done));
    chk({tag, "_err_pulses"}, 32'(n_err - b_err), 32'(err));
    chk({tag, "_mis_pulses"}, 32'(n_mis - b_mis), 32'(mis));
  endtask

  task automatic present(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    st_valid_in = 1'b1;
    funct3_in   = f3;
    addr_in     = a;
    rs2_in      = d;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    wr_t w;
    w.addr = a; w.wdata = d; w.wmask = m;
    exp_q.push_back(w);
  endtask

  // Bus observer: every cycle with a live request must match the queue head.
  always @(negedge clk_in) begin
    if (rst_in) begin
      hs_prev = 1'b0;
    end else begin
      chk("done_timing", 32'(done_out), 32'(hs_prev));
      if (bus_req_out) begin
        n_req++;
        if (exp_q.size() == 0) begin
          chk("req_unexpected", 32'(bus_req_out), 32'd0);
        end else begin
          chk("bus_addr", bus_addr_out, exp_q[0].addr);
          chk("bus_wdata", bus_wdata_out, exp_q[0].wdata);
          chk("bus_wmask", 32'(bus_wmask_out), 32'(exp_q[0].wmask));
          if (bus_ready_in) void'(exp_q.pop_front());
        end
      end
      if (stall_out)      n_stall++;
      if (done_out)       n_done++;
      if (bus_err_out)    n_err++;
      if (misaligned_out) n_mis++;
      hs_prev = bus_req_out && bus_ready_in;
    end
  end

  initial begin
    rst_in = 1'b1; st_valid_in = 1'b0; funct3_in = 3'b000;
    addr_in = '0; rs2_in = '0; bus_ready_in = 1'b0;
    cyc(2);
    chk("rst_req", 32'(bus_req_out), 32'd0);
    chk("rst_addr", bus_addr_out, 32'd0);
    chk("rst_wdata", bus_wdata_out, 32'd0);
    chk("rst_wmask", 32'(bus_wmask_out), 32'd0);
    chk("rst_stall", 32'(stall_out), 32'd0);
    chk("rst_done", 32'(done_out), 32'd0);
    chk("rst_mis", 32'(misaligned_out), 32'd0);
    chk("rst_misaddr", misaligned_addr_out, 32'd0);
    chk("rst_err", 32'(bus_err_out), 32'd0);
    rst_in = 1'b0;
    cyc(1);

    // SB to byte lane 3, accepted immediately
    snap();
    bus_ready_in = 1'b1;
    present(3'b000, 32'h0000_1003, 32'hAABB_CCDD);
    push(32'h0000_1000, 32'hDDDD_DDDD, 4'b1000);
    cyc(1);
    st_valid_in = 1'b0;
    cyc(1);
    chk("sb_done_now", 32'(done_out), 32'd1);
    bus_ready_in = 1'b0;
    cyc(2);
    chk_counts("sb", 1, 0, 1, 0, 0);

    // SH upper half, three wait cycles; handshake lands on the timeout boundary
    snap();
    present(3'b001, 32'h0000_2002, 32'h1234_5678);
    push(32'h0000_2000, 32'h5678_5678, 4'b1100);
    cyc(1);
    st_valid_in = 1'b0;
    cyc(3);
    bus_ready_in = 1'b1;
    cyc(1);
    bus_ready_in = 1'b0;
    cyc(2);
    chk_counts("sh", 4, 3, 1, 0, 0);

    // misaligned SW, then misaligned SH, then illegal funct3
    snap();
    present(3'b010, 32'h0000_3001, 32'h0BAD_0BAD);
    cyc(1);
    st_valid_in = 1'b0;
    chk("sw_mis_pulse", 32'(misaligned_out), 32'd1);
    chk("sw_mis_addr", misaligned_addr_out, 32'h0000_3001);
    cyc(2);
    present(3'b001, 32'h0000_3001, 32'h0BAD_0BAD);
    cyc(1);
    st_valid_in = 1'b0;
    chk("sh_mis_addr", misaligned_addr_out, 32'h0000_3001);
    cyc(2);
    present(3'b011, 32'h0000_3100, 32'h0BAD_0BAD);
    cyc(1);
    st_valid_in = 1'b0;
    cyc(2);
    chk("ill_mis_addr", misaligned_addr_out, 32'h0000_3001);
    chk_counts("mis", 0, 0, 0, 0, 2);

    // back-to-back SWs, second accepted in the first one's handshake cycle
    snap();
    present(3'b010, 32'h0000_4000, 32'h1111_1111);
    push(32'h0000_4000, 32'h1111_1111, 4'b1111);
    cyc(1);
    bus_ready_in = 1'b1;
    present(3'b010, 32'h0000_4004, 32'h2222_2222);
    push(32'h0000_4004, 32'h2222_2222, 4'b1111);
    cyc(1);
    st_valid_in = 1'b0;
    chk("b2b_second_req", 32'(bus_req_out), 32'd1);
    cyc(1);
    bus_ready_in = 1'b0;
    cyc(2);
    chk_counts("b2b", 2, 0, 2, 0, 0);

    // timeout abort after 4 waiting cycles
    snap();
    present(3'b010, 32'h0000_5000, 32'hCAFE_BABE);
    push(32'h0000_5000, 32'hCAFE_BABE, 4'b1111);
    cyc(1);
    st_valid_in = 1'b0;
    cyc(4);
    chk("to_req_dropped", 32'(bus_req_out), 32'd0);
    chk("to_err_now", 32'(bus_err_out), 32'd1);
    chk("to_stall_idle", 32'(stall_out), 32'd0);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    cyc(2);
    chk_counts("to", 4, 4, 0, 1, 0);

    // asynchronous reset in the middle of a request
    present(3'b010, 32'h0000_6000, 32'h6666_6666);
    push(32'h0000_6000, 32'h6666_6666, 4'b1111);
    cyc(1);
    st_valid_in = 1'b0;
    cyc(1);
    #2;
    rst_in = 1'b1;
    #1;
    chk("arst_req", 32'(bus_req_out), 32'd0);
    chk("arst_stall", 32'(stall_out), 32'd0);
    exp_q.delete();
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    snap();
    bus_ready_in = 1'b1;
    cyc(4);
    chk_counts("arst", 0, 0, 0, 0, 0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/store_unit.md
Name: store_unit

Overview:
- Store-side counterpart of the load/writeback path in the RV32I core.
- Takes a store instruction's effective address (iadder output), rs2 data and funct3 from the execute stage.
- Aligns the data into byte lanes, generates the byte write mask, and drives a valid/ready write request onto the data-memory bus.
- Holds the request until the bus accepts it, stalls the pipeline while a write is outstanding, and flags misaligned stores and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 255: maximum REQ-state cycles without bus_ready_in before abort. 0 disables the timeout.
- CNT_W, 8: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk_in  input  1  core clock; all state updates on the rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- st_valid_in  input  1  a store instruction is presented this cycle.
- funct3_in  input  3  000=SB, 001=SH, 010=SW; any other value is ignored.
- addr_in  input  32  effective byte address.
- rs2_in  input  32  store data, unaligned (LSBs).
- bus_ready_in  input  1  the bus accepts the request this cycle.
- bus_req_out  output  1  write request valid.
- bus_addr_out  output  32  word-aligned address, {addr[31:2],2'b00}.
- bus_wdata_out  output  32  lane-aligned write data.
- bus_wmask_out  output  4  byte enables; bit i enables byte lane i.
- stall_out  output  1  the pipeline must hold the instruction in execute.
- done_out  output  1  one-cycle pulse when a write completes.
- misaligned_out  output  1  one-cycle pulse for a misaligned store.
- misaligned_addr_out  output  32  faulting address, held until the next misaligned event.
- bus_err_out  output  1  one-cycle pulse when a request is aborted by timeout.

Behaviour:
- States: IDLE and REQ. All bus_* outputs are registered.
- Reset (asynchronous, takes effect immediately, including mid-REQ):
  - state returns to IDLE.
  - All outputs are driven to 0, including misaligned_addr_out.
  - The timeout counter is cleared.
  - Any in-flight request is dropped; it is never replayed.
- Lane formatting:
  - SB: wdata = {4{rs2[7:0]}}, mask = 4'b0001 << addr[1:0].
  - SH: wdata = {2{rs2[15:0]}}, mask = addr[1] ? 4'b1100 : 4'b0011.
  - SW: wdata = rs2, mask = 4'b1111.
- Misaligned: SH with addr[0]=1, or SW with addr[1:0]!=0.
  - No bus request is issued.
  - misaligned_out pulses on the next cycle and misaligned_addr_out is updated with addr_in.
  - State does not change.
- Accept condition: st_valid_in=1, funct3 legal, address aligned, and (state==IDLE, or state==REQ with bus_ready_in=1).
  - On accept, at the clock edge: bus outputs load the new request, bus_req_out becomes 1, state goes to REQ, and the timeout counter clears.
  - Latency: request visible 1 cycle after acceptance.
- In REQ: bus_req_out, bus_addr_out, bus_wdata_out and bus_wmask_out stay stable until a cycle in which bus_ready_in=1.
  - That cycle is the handshake; done_out pulses on the following cycle.
  - With no new accept in the handshake cycle: state returns to IDLE and bus_req_out goes to 0.
  - With a new accept in the handshake cycle: stay in REQ with the new request. This gives back-to-back stores with no bubble.
- stall_out = (state==REQ) && !bus_ready_in.
  - This is combinational from bus_ready_in.
  - It is 0 in IDLE, so the store leaves execute in its accept cycle; the unit owns it afterwards.
- A store arriving while stall_out=1 is not accepted. The pipeline holds it (st_valid_in stays high) until stall_out drops.
- Timeout:
  - The counter increments each REQ cycle with bus_ready_in=0.
  - When the counter reaches TIMEOUT_CYCLES: go to IDLE, bus_req_out goes to 0, bus_err_out pulses, and done_out is not asserted.
  - If bus_ready_in=1 in the same cycle the counter hits the limit, the handshake wins and no error is raised.
- Illegal funct3 with st_valid_in=1: no request, no pulse, no state change.
- Simultaneous misaligned store and handshake: the handshake completes normally, and misaligned_out also pulses.

Test Plan:
1. SB, addr=0x0000_1003, rs2=0xAABB_CCDD, bus_ready_in=1 in the first REQ cycle -> bus_addr_out=0x0000_1000, wdata=0xDDDD_DDDD, mask=4'b1000, bus_req_out high 1 cycle, done_out pulses the cycle after, stall_out never high.
2. SH, addr=0x2002, rs2=0x1234_5678, bus_ready_in low 3 cycles then high -> wdata=0x5678_5678, mask=4'b1100; outputs stable for 4 REQ cycles; stall_out high exactly 3 cycles; one done_out.
3. SW, addr=0x3001 -> no bus_req_out; misaligned_out pulses once; misaligned_addr_out=0x0000_3001. Repeat with SH, addr=0x3001 -> same result.
4. Two SWs back-to-back (0x4000/0x1111_1111, then 0x4004/0x2222_2222), second presented during the handshake cycle -> second request appears the next cycle; 2 done_out pulses; no IDLE cycle between.
5. TIMEOUT_CYCLES=4, SW with bus_ready_in held 0 -> bus_req_out drops after 4 waiting cycles; bus_err_out pulses once; no done_out; state returns to IDLE.
6. rst_in asserted mid-REQ (asynchronously, between edges) -> bus_req_out and stall_out drop to 0 immediately; after release there is no request until a new st_valid_in.
